// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line-level constants
// Shared by the transmit block and the receive path so both agree on
// state numbering and on the polarity of idle, start and stop bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LINE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// rtl/flex_pts_sr.sv - parameterised parallel-to-serial shift register
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset (register -> all ones)
//   load_enable     capture parallel_in (has priority over shift_enable)
//   shift_enable    shift one place toward the output end, filling with ones
//   parallel_in     word to load
//   serial_out      current output-end bit (straight from the register)
//   serial_peek     bit that reaches the output end after one more shift
module flex_pts_sr #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out,
    output logic                serial_peek
);

    logic [NUM_BITS-1:0] sr_q;
    logic [NUM_BITS-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_enable) begin
            sr_d = parallel_in;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                sr_d = {sr_q[NUM_BITS-2:0], 1'b1};
            end else begin
                sr_d = {1'b1, sr_q[NUM_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    // The peek output lets the owner register the line one cycle early
    // without needing a copy of the whole register.
    assign serial_out  = SHIFT_MSB ? sr_q[NUM_BITS-1] : sr_q[0];
    assign serial_peek = SHIFT_MSB ? sr_q[NUM_BITS-2] : sr_q[1];

endmodule

// File: rtl/uart_tx_block.sv
// rtl/uart_tx_block.sv - UART transmitter: start, LSB-first data, optional parity, stop
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   tx_data     word to send, sampled only on accept
//   tx_valid    tx_data is valid
//   tx_ready    high in IDLE only
//   serial_out  registered serial line, idles at 1
//   frame_done  one-cycle pulse on the last cycle of the stop bit
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int NUM_DATA_BITS = 8,
    parameter int BIT_PERIOD    = 10
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic                     serial_out,
    output logic                     frame_done
);

    localparam int PW = $clog2(BIT_PERIOD);
    localparam int BW = $clog2(NUM_DATA_BITS);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NUM_DATA_BITS - 1);

    tx_state_t     state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          serial_out_q, serial_out_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          bit_end;
    logic          load_en;
    logic          shift_en;
    logic          pts_serial;
    logic          pts_peek;

`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    flex_pts_sr #(
        .NUM_BITS  (NUM_DATA_BITS),
        .SHIFT_MSB (1'b0)
    ) u_data_sr (
        .clk          (clk),
        .n_rst        (n_rst),
        .load_enable  (load_en),
        .shift_enable (shift_en),
        .parallel_in  (tx_data),
        .serial_out   (pts_serial),
        .serial_peek  (pts_peek)
    );

    assign accept  = tx_valid && (state_q == IDLE);
    assign bit_end = (period_q == PERIOD_LAST);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        bit_d    = bit_q;
        load_en  = 1'b0;
        shift_en = 1'b0;

        case (state_q)
            IDLE: begin
                period_d = '0;
                if (accept) begin
                    state_d = START;
                    bit_d   = '0;
                    load_en = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d  = DATA;
                    period_d = '0;
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    period_d = '0;
                    shift_en = 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d  = STOP;
                    period_d = '0;
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d  = IDLE;
                    period_d = '0;
                end else begin
                    period_d = period_q + PW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                period_d = '0;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is fixed at accept so tx_data may change immediately.
    always_comb begin
        parity_d = parity_q;
        if (accept) begin
            parity_d = ^tx_data;
        end
    end
`endif

    // The line is registered from the next state, so the value shown in a
    // cycle is decided on the edge that enters it. On a shift edge the
    // register's current bit is stale, hence the peek at the next bit.
    always_comb begin
        serial_out_d = IDLE_LINE;
        case (state_d)
            IDLE:   serial_out_d = IDLE_LINE;
            START:  serial_out_d = START_BIT;
            DATA:   serial_out_d = shift_en ? pts_peek : pts_serial;
`ifdef UART_TX_PARITY_EN
            PARITY: serial_out_d = parity_q;
`endif
            STOP:   serial_out_d = STOP_BIT;
            default: serial_out_d = IDLE_LINE;
        endcase
    end

    assign frame_done_d = (state_d == STOP) && (period_d == PERIOD_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            period_q     <= '0;
            bit_q        <= '0;
            serial_out_q <= IDLE_LINE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            bit_q        <= bit_d;
            serial_out_q <= serial_out_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx_ready   = (state_q == IDLE);
    assign serial_out = serial_out_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_block.sv
// tb/tb_uart_tx_block.sv - scoreboard bench for uart_tx_block
`timescale 1ns/1ps
module tb_uart_tx_block;

    localparam int BP = 10;
    localparam int NB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 2 + NB + PB;
    localparam int FLEN  = NBITS * BP;

    logic          clk      = 1'b0;
    logic          n_rst    = 1'b1;
    logic [NB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          serial_out;
    logic          frame_done;

    uart_tx_block #(
        .NUM_DATA_BITS (NB),
        .BIT_PERIOD    (BP)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NB-1:0] data;
        logic          par;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic logic exp_bit(input exp_t e, input int b);
        if (b == 0) return 1'b0;
        if (b <= NB) return e.data[b-1];
        if (PB == 1 && b == NB + 1) return e.par;
        return 1'b1;
    endfunction

    // Monitor: frames are recognised by the falling start edge and checked
    // cycle by cycle against the next queued expectation.
    exp_t cur;
    bit   in_frame    = 1'b0;
    int   k           = 0;
    int   b_idx       = 0;
    int   bad_cnt     = 0;
    logic bad_val     = 1'b0;
    int   done_at     = -1;
    int   frames_done = 0;
    int   start_cyc   = 0;
    int   done_cyc    = -1000;
    int   gap         = 0;

    always @(negedge clk) begin
        if (!n_rst) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && frame_done) begin
                checks++;
                failures++;
                $display("FAIL stray_frame_done at cyc %0d", cyc);
            end
            if (!in_frame && serial_out == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame at cyc %0d", cyc);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                in_frame  = 1'b1;
                k         = 0;
                bad_cnt   = 0;
                done_at   = -1;
                gap       = cyc - done_cyc;
                start_cyc = cyc;
            end
            if (in_frame) begin
                b_idx = k / BP;
                if (serial_out !== exp_bit(cur, b_idx)) begin
                    bad_cnt++;
                    bad_val = serial_out;
                end
                if (frame_done) done_at = (done_at < 0) ? k : -2;
                if (k % BP == BP - 1) begin
                    checks++;
                    if (bad_cnt != 0) begin
                        failures++;
                        $display("FAIL frame_bit%0d data=%02h got=%b want=%b cycles_wrong=%0d",
                                 b_idx, cur.data, bad_val, exp_bit(cur, b_idx), bad_cnt);
                    end
                    bad_cnt = 0;
                end
                k++;
                if (k == FLEN) begin
                    checks++;
                    if (done_at != FLEN - 1) begin
                        failures++;
                        $display("FAIL frame_done_pos data=%02h got=%0d want=%0d",
                                 cur.data, done_at, FLEN - 1);
                    end
                    in_frame = 1'b0;
                    frames_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    int acc_cyc = 0;

    task automatic wait_ready_accept();
        int n;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            check("accept_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk);
            #1;
            acc_cyc  = cyc;
            tx_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [NB-1:0] d, input logic p);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back({d, p});
        wait_ready_accept();
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_done < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (frames_done < target) check("frame_timeout", 32'(frames_done), 32'(target));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset, asserted mid-cycle before any edge
        #3 n_rst = 1'b0;
        #1;
        check("rst_line_async", 32'(serial_out), 32'd1);
        check("rst_ready_async", 32'(tx_ready), 32'd1);
        check("rst_done_async", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        check("rst_line_edge", 32'(serial_out), 32'd1);
        check("rst_ready_edge", 32'(tx_ready), 32'd1);
        check("rst_done_edge", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        check("rel_line", 32'(serial_out), 32'd1);
        check("rel_ready", 32'(tx_ready), 32'd1);
        check("rel_done", 32'(frame_done), 32'd0);

        // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1
        send(8'hA5, 1'b0);
        #1;
        check("busy_ready_after_accept", 32'(tx_ready), 32'd0);
        wait_frames(1);
        check("start_latency", 32'(start_cyc - acc_cyc), 32'd0);

        // Data hold: source changes tx_data right after accept
        send(8'hFF, 1'b0);
        @(posedge clk); #1;
        tx_data = 8'h00;
        wait_frames(2);

        // Busy rejection: 0x3C offered during data bits of 0x81
        send(8'h81, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("busy_ready", 32'(tx_ready), 32'd0);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        exp_q.push_back({8'h3C, 1'b0});
        wait_ready_accept();
        wait_frames(3);
        @(negedge clk);
        check("frame_gap", 32'(gap), 32'd2);
        wait_frames(4);

        // Reset during data bit 3 of 0x00
        send(8'h00, 1'b0);
        repeat (45) @(posedge clk);
        #1;
        check("midrst_pre_line", 32'(serial_out), 32'd0);
        #1 n_rst = 1'b0;
        #1;
        check("midrst_line", 32'(serial_out), 32'd1);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_done", 32'(frame_done), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rel_ready", 32'(tx_ready), 32'd1);
        check("midrst_rel_line", 32'(serial_out), 32'd1);
        send(8'h55, 1'b0);
        wait_frames(5);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1);
        wait_frames(6);
        send(8'h03, 1'b0);
        wait_frames(7);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_line_end", 32'(serial_out), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
- Serial transmit end of the byte link; counterpart to the receive path built on the LSB-first serial-to-parallel shift register.
- Accepts a parallel word over a valid/ready handshake and frames it as start bit, data bits (LSB first), optional parity, and stop bit.
- Drives one serial line that idles at 1.
- Sits between the packet/control logic and the chip's serial output pad.

Parameters:
- NUM_DATA_BITS, 8, data bits per frame (legal 5–9).
- BIT_PERIOD, 10, clock cycles per serial bit (legal ≥ 2).

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous active-low reset
- tx_data  input  NUM_DATA_BITS  word to transmit; sampled only on accept
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word (IDLE only)
- serial_out  output  1  serial line; idle/inactive value 1
- frame_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE, serial_out = 1, tx_ready = 1, frame_done = 0.
  - Bit counter and period counter = 0; the shift register is loaded with all ones.
- Accept: on a rising edge where tx_valid & tx_ready, tx_data is latched into the shift register and state goes to START.
  - tx_data may change freely after accept.
  - tx_valid while tx_ready = 0 is ignored; the word is not captured and the source must hold it.
- States and transitions:
  - IDLE: serial_out = 1, tx_ready = 1. Goes to START on accept.
  - START: serial_out = 0 for BIT_PERIOD cycles, then DATA.
  - DATA: serial_out = shift register bit 0 for BIT_PERIOD cycles per bit. The register shifts right (ones fill at the MSB) on the last cycle of each bit period. After NUM_DATA_BITS bits, goes to PARITY if PARITY_EN is defined, else STOP.
  - STOP: serial_out = 1 for BIT_PERIOD cycles. frame_done = 1 on the last cycle, then IDLE.
- Latency:
  - serial_out falls to 0 in the cycle after the accept edge.
  - Frame length = (2 + NUM_DATA_BITS [+1 with parity]) × BIT_PERIOD cycles.
  - Minimum gap between frames = 1 idle cycle at 1, since tx_ready is asserted only in IDLE.
- Period counter:
  - Counts 0..BIT_PERIOD-1 and wraps to 0 on each bit boundary.
  - Width = $clog2(BIT_PERIOD).
- Bit counter:
  - Counts data bits 0..NUM_DATA_BITS-1.
  - Clears on entry to START.
- Outputs:
  - serial_out is registered; no combinational path from inputs to serial_out.
  - tx_ready is a decode of state == IDLE.
- Reset mid-frame: line returns to 1 immediately (asynchronous) and the frame is abandoned. The next frame starts cleanly after reset release.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - Parity bit is the XOR of the latched data word (even parity), computed at accept, held for BIT_PERIOD cycles.
- Undefined:
  - No PARITY state, no parity register.
  - Frame is start + data + stop.

Decomposition:
- Shared package uart_pkg:
  - State enum tx_state_t (IDLE, START, DATA, PARITY, STOP), 3-bit encoding.
  - Constants IDLE_LINE = 1'b1, START_BIT = 1'b0, STOP_BIT = 1'b1. These are shared with the receiver.
- Sub-module flex_pts_sr:
  - Parameterised parallel-to-serial shift register (NUM_BITS, SHIFT_MSB = 0) with load_enable, shift_enable, parallel_in, serial_out.
  - Reset value all ones.
  - Instantiated for the data path; the controller FSM and counters live in uart_tx_block.

Test Plan (defaults BIT_PERIOD = 10, NUM_DATA_BITS = 8, clock period 10 ns):
- Power-on reset:
  - Stimulus: assert n_rst = 0 mid-cycle.
  - Required: serial_out = 1, tx_ready = 1, frame_done = 0, both before and after a clock edge, and after release.
- Single frame 0xA5:
  - Stimulus: tx_valid pulse with tx_data = 0xA5.
  - Required: line sequence 0, then 1,0,1,0,0,1,0,1, then 1, each held exactly 10 cycles. Start bit begins 1 cycle after accept; frame_done pulses once at cycle 100.
- Data hold:
  - Stimulus: change tx_data to 0x00 one cycle after accepting 0xFF.
  - Required: all 8 data bits = 1.
- Busy rejection:
  - Stimulus: tx_valid with 0x3C during the DATA state of a 0x81 frame.
  - Required: tx_ready = 0 and the 0x81 frame is unchanged. The held 0x3C is accepted on the first IDLE cycle after the stop bit, giving exactly one idle 1 cycle between frames.
- Reset mid-frame:
  - Stimulus: n_rst = 0 during data bit 3 of 0x00.
  - Required: serial_out = 1 asynchronously and tx_ready = 1 after release. A subsequent 0x55 frame is correct.
- Parity build (UART_TX_PARITY_EN):
  - 0x07 → parity bit 1; 0x03 → parity bit 0.
  - Frame length is 110 cycles.
